// File: rtl/fpga_cfg_loader.sv
// Serial configuration loader: hunts for a sync word, then deserializes framed config bits
// into the fabric select buses. Optional parity check on each frame is enabled by CFG_PARITY_EN.
module fpga_cfg_loader #(
    parameter int          wire_width  = 7,
    parameter int          lb_cfg_size = 10,
    parameter int          fpga_width  = 5,
    parameter int          fpga_height = 5,
    parameter logic [7:0]  SYNC_WORD   = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_din,
    input  logic cfg_valid,
    output logic cfg_ready,
    output logic [fpga_height*fpga_width*wire_width*12-1:0]                      brbselect,
    output logic [(fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12-1:0]   bsbselect,
    output logic [fpga_width*fpga_height*lb_cfg_size-1:0]                        lbselect,
    output logic [2*wire_width*fpga_height-1:0]                                  leftioselect,
    output logic [2*wire_width*fpga_height-1:0]                                  rightioselect,
    output logic [2*wire_width*fpga_height-1:0]                                  topioselect,
    output logic [2*wire_width*fpga_height-1:0]                                  bottomioselect,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_ok,
    output logic cfg_error
);

    localparam int BRB_W  = fpga_height*fpga_width*wire_width*12;
    localparam int BSB_W  = (fpga_height-1)*(fpga_width-1)*wire_width*wire_width*12;
    localparam int LB_W   = fpga_width*fpga_height*lb_cfg_size;
    localparam int IO_W   = 2*wire_width*fpga_height;
    localparam int BRB_IW = $clog2(BRB_W);
    localparam int BSB_IW = $clog2(BSB_W);
    localparam int LB_IW  = $clog2(LB_W);
    localparam int IO_IW  = $clog2(IO_W);

    typedef enum logic [2:0] {
        S_HUNT, S_TARGET, S_LENGTH, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          sh_q, sh_d;
    logic [2:0]          tgt_q, tgt_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;
    logic [BRB_W-1:0]    brb_q, brb_d;
    logic [BSB_W-1:0]    bsb_q, bsb_d;
    logic [LB_W-1:0]     lb_q, lb_d;
    logic [IO_W-1:0]     left_q, left_d;
    logic [IO_W-1:0]     right_q, right_d;
    logic [IO_W-1:0]     top_q, top_d;
    logic [IO_W-1:0]     bot_q, bot_d;
`ifdef CFG_PARITY_EN
    logic                par_q, par_d;
`endif
    logic                xfer;

    function automatic logic [16:0] tgt_width(input logic [2:0] t);
        case (t)
            3'd0:    return 17'(BRB_W);
            3'd1:    return 17'(BSB_W);
            3'd2:    return 17'(LB_W);
            3'd3,
            3'd4,
            3'd5,
            3'd6:    return 17'(IO_W);
            default: return 17'd0;
        endcase
    endfunction

    // End of payload: without parity there is no CHECK bit, so the frame commits at once.
    function automatic state_t after_payload();
`ifdef CFG_PARITY_EN
        return S_CHECK;
`else
        return S_DONE;
`endif
    endfunction

    assign xfer = cfg_valid & ready_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        err_d   = err_q;
        brb_d   = brb_q;
        bsb_d   = bsb_q;
        lb_d    = lb_q;
        left_d  = left_q;
        right_d = right_q;
        top_d   = top_q;
        bot_d   = bot_q;
`ifdef CFG_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_HUNT: begin
                if (xfer) begin
                    sh_d = {cfg_din, sh_q[7:1]};
                    if (sh_d == SYNC_WORD) begin
                        state_d = S_TARGET;
                        sh_d    = '0;
                        cnt_d   = '0;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
`ifdef CFG_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end
                end
            end
            S_TARGET: begin
                if (xfer) begin
                    tgt_d[cnt_q[1:0]] = cfg_din;
                    if (cnt_q == 16'd2) begin
                        cnt_d   = '0;
                        state_d = (tgt_d == 3'd7) ? S_ERROR : S_LENGTH;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_LENGTH: begin
                if (xfer) begin
                    len_d[cnt_q[3:0]] = cfg_din;
                    if (cnt_q == 16'd15) begin
                        cnt_d = '0;
                        if ({1'b0, len_d} > tgt_width(tgt_q))
                            state_d = S_ERROR;
                        else if (len_d == 16'd0)
                            state_d = after_payload();
                        else
                            state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    case (tgt_q)
                        3'd0:    brb_d[cnt_q[BRB_IW-1:0]]  = cfg_din;
                        3'd1:    bsb_d[cnt_q[BSB_IW-1:0]]  = cfg_din;
                        3'd2:    lb_d[cnt_q[LB_IW-1:0]]    = cfg_din;
                        3'd3:    left_d[cnt_q[IO_IW-1:0]]  = cfg_din;
                        3'd4:    right_d[cnt_q[IO_IW-1:0]] = cfg_din;
                        3'd5:    top_d[cnt_q[IO_IW-1:0]]   = cfg_din;
                        default: bot_d[cnt_q[IO_IW-1:0]]   = cfg_din;
                    endcase
`ifdef CFG_PARITY_EN
                    par_d = par_q ^ cfg_din;
`endif
                    if (cnt_q == len_q - 16'd1) begin
                        cnt_d   = '0;
                        state_d = after_payload();
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_CHECK: begin
`ifdef CFG_PARITY_EN
                if (xfer)
                    state_d = (cfg_din == par_q) ? S_DONE : S_ERROR;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE, S_ERROR: state_d = S_HUNT;
            default:         state_d = S_HUNT;
        endcase

        done_d  = (state_d == S_DONE);
        if (state_d == S_DONE)
            ok_d = 1'b1;
        if (state_d == S_ERROR)
            err_d = 1'b1;
        ready_d = !(state_d == S_DONE || state_d == S_ERROR);
        busy_d  = (state_d == S_TARGET || state_d == S_LENGTH ||
                   state_d == S_DATA   || state_d == S_CHECK);
    end

    // Reset also clears the select buses so an aborted frame never leaves partial config behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            sh_q    <= '0;
            tgt_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            brb_q   <= '0;
            bsb_q   <= '0;
            lb_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
            top_q   <= '0;
            bot_q   <= '0;
`ifdef CFG_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            brb_q   <= brb_d;
            bsb_q   <= bsb_d;
            lb_q    <= lb_d;
            left_q  <= left_d;
            right_q <= right_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
`ifdef CFG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign cfg_ready      = ready_q;
    assign cfg_busy       = busy_q;
    assign cfg_done       = done_q;
    assign cfg_ok         = ok_q;
    assign cfg_error      = err_q;
    assign brbselect      = brb_q;
    assign bsbselect      = bsb_q;
    assign lbselect       = lb_q;
    assign leftioselect   = left_q;
    assign rightioselect  = right_q;
    assign topioselect    = top_q;
    assign bottomioselect = bot_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: frame-level reference model tracks expected buses and flags,
// compared against the loader every cycle; directed frames plus randomized frames.
module tb_fpga_cfg_loader;

    localparam int BRB_W = 2100;
    localparam int BSB_W = 9408;
    localparam int LB_W  = 250;
    localparam int IO_W  = 70;

    logic clk = 1'b0;
    logic rst_n, cfg_din, cfg_valid;
    logic cfg_ready, cfg_busy, cfg_done, cfg_ok, cfg_error;
    logic [BRB_W-1:0] brbselect;
    logic [BSB_W-1:0] bsbselect;
    logic [LB_W-1:0]  lbselect;
    logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;

    fpga_cfg_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg_din(cfg_din), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .brbselect(brbselect), .bsbselect(bsbselect),
        .lbselect(lbselect), .leftioselect(leftioselect), .rightioselect(rightioselect),
        .topioselect(topioselect), .bottomioselect(bottomioselect),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_ok(cfg_ok), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [BRB_W-1:0] e_brb;
    logic [BSB_W-1:0] e_bsb;
    logic [LB_W-1:0]  e_lb;
    logic [IO_W-1:0]  e_left, e_right, e_top, e_bot;
    bit e_ready, e_busy, e_done, e_ok, e_err;
    bit dbuf[256];

    task automatic exp_reset();
        e_brb = '0; e_bsb = '0; e_lb = '0;
        e_left = '0; e_right = '0; e_top = '0; e_bot = '0;
        e_ready = 1; e_busy = 0; e_done = 0; e_ok = 0; e_err = 0;
    endtask

    function automatic int width_of(input int t);
        case (t)
            0: return BRB_W;
            1: return BSB_W;
            2: return LB_W;
            3, 4, 5, 6: return IO_W;
            default: return 0;
        endcase
    endfunction

    task automatic exp_write(input int t, input int k, input bit b);
        case (t)
            0: e_brb[k]   = b;
            1: e_bsb[k]   = b;
            2: e_lb[k]    = b;
            3: e_left[k]  = b;
            4: e_right[k] = b;
            5: e_top[k]   = b;
            default: e_bot[k] = b;
        endcase
    endtask

    task automatic cmp_val(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cmp_bus(input string nm, input logic [BSB_W-1:0] act, input logic [BSB_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            for (int i = 0; i < BSB_W; i++) begin
                if (act[i] !== req[i]) begin
                    $display("FAIL %s: bit %0d actual=%b required=%b at %0t", nm, i, act[i], req[i], $time);
                    break;
                end
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_bus("brbselect", BSB_W'(brbselect), BSB_W'(e_brb));
            cmp_bus("bsbselect", bsbselect, e_bsb);
            cmp_bus("lbselect", BSB_W'(lbselect), BSB_W'(e_lb));
            cmp_bus("leftioselect", BSB_W'(leftioselect), BSB_W'(e_left));
            cmp_bus("rightioselect", BSB_W'(rightioselect), BSB_W'(e_right));
            cmp_bus("topioselect", BSB_W'(topioselect), BSB_W'(e_top));
            cmp_bus("bottomioselect", BSB_W'(bottomioselect), BSB_W'(e_bot));
            cmp_val("cfg_ready", 32'(cfg_ready), 32'(e_ready));
            cmp_val("cfg_busy", 32'(cfg_busy), 32'(e_busy));
            cmp_val("cfg_done", 32'(cfg_done), 32'(e_done));
            cmp_val("cfg_ok", 32'(cfg_ok), 32'(e_ok));
            cmp_val("cfg_error", 32'(cfg_error), 32'(e_err));
        end
    end

    // gmax > 0: random gap 0..gmax idle cycles; gmax < 0: exactly -gmax idle cycles.
    task automatic put_bit(input bit b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : -gmax;
        repeat (g) begin
            cfg_valid = 0;
            cfg_din = 1'($urandom);
            @(posedge clk); #1;
        end
        cfg_valid = 1;
        cfg_din = b;
        @(posedge clk); #1;
        cfg_valid = 0;
    endtask

    task automatic frame_end(input bit good);
        e_busy = 0; e_ready = 0;
        if (good) begin e_done = 1; e_ok = 1; end
        else e_err = 1;
        @(posedge clk); #1;
        e_done = 0; e_ready = 1;
    endtask

    // Sends one frame; stop_at >= 0 abandons the frame after that many data bits.
    task automatic run_frame(input int t, input int len, input bit bad_par, input int gmax, input int stop_at);
        logic [7:0]  sw;
        logic [2:0]  tv;
        logic [15:0] lv;
        bit par;
        sw = 8'hA5;
        tv = 3'(t);
        lv = 16'(len);
        par = 0;
        repeat ($urandom_range(0, 2)) put_bit(0, gmax);
        for (int i = 0; i < 8; i++) put_bit(sw[i], gmax);
        e_busy = 1; e_ok = 0; e_err = 0;
        for (int i = 0; i < 3; i++) put_bit(tv[i], gmax);
        if (t == 7) begin frame_end(0); return; end
        for (int i = 0; i < 16; i++) put_bit(lv[i], gmax);
        if (len > width_of(t)) begin frame_end(0); return; end
        for (int k = 0; k < len; k++) begin
            if (k == stop_at) return;
            put_bit(dbuf[k], gmax);
            exp_write(t, k, dbuf[k]);
            par ^= dbuf[k];
        end
`ifdef CFG_PARITY_EN
        put_bit(par ^ bad_par, gmax);
        frame_end(!bad_par);
`else
        frame_end(1);
`endif
    endtask

    initial begin
        int t, len, w, r;
        bit bad;
        rst_n = 1; cfg_valid = 0; cfg_din = 0;
        exp_reset();
        #2 rst_n = 0;
        #1;
        cmp_val("reset_ready", 32'(cfg_ready), 32'd1);
        cmp_val("reset_flags", {28'd0, cfg_busy, cfg_done, cfg_ok, cfg_error}, 32'd0);
        chk_en = 1;
        @(negedge clk); #2 rst_n = 1;

        // Bottom IO, LEN=2, data bit0=1.
        dbuf[0] = 1; dbuf[1] = 0;
        run_frame(6, 2, 0, 0, -1);
        cmp_val("t2_bot_lo", 32'(bottomioselect[1:0]), 32'h1);
        cmp_val("t2_ok", 32'(cfg_ok), 32'd1);
        cmp_val("t2_busy_done", {30'd0, cfg_busy, cfg_done}, 32'd0);

        // BRB: all-ones byte, then a 6-bit overwrite leaving bits 6,7 intact.
        for (int k = 0; k < 8; k++) dbuf[k] = 1;
        run_frame(0, 8, 0, 2, -1);
        for (int k = 0; k < 6; k++) dbuf[k] = (k == 1);
        run_frame(0, 6, 0, 2, -1);
        cmp_val("t3_brb_lo", 32'(brbselect[7:0]), 32'hC2);

        // Invalid target, then recovery.
        run_frame(7, 0, 0, 1, -1);
        cmp_val("t4_err", 32'(cfg_error), 32'd1);
        cmp_val("t4_ok", 32'(cfg_ok), 32'd0);
        dbuf[0] = 1;
        run_frame(5, 1, 0, 1, -1);
        cmp_val("t4_err_cleared", 32'(cfg_error), 32'd0);
        cmp_val("t4_top0", 32'(topioselect[0]), 32'd1);

        // LB length boundary: 251 rejected, 250 accepted.
        run_frame(2, 251, 0, 0, -1);
        cmp_val("t5_err", 32'(cfg_error), 32'd1);
        for (int k = 0; k < 250; k++) dbuf[k] = k[0];
        run_frame(2, 250, 0, 0, -1);
        cmp_val("t5_lb_hi", 32'(lbselect[249:246]), 32'hA);

        // Left IO, data 0111; parity bit deliberately wrong when parity is enabled.
        dbuf[0] = 1; dbuf[1] = 1; dbuf[2] = 1; dbuf[3] = 0;
        for (int rep = 0; rep < 2; rep++) begin
            run_frame(3, 4, 1, (rep == 0) ? 0 : -5, -1);
            cmp_val("t6_left_lo", 32'(leftioselect[3:0]), 32'h7);
`ifdef CFG_PARITY_EN
            cmp_val("t6_err_ok", {30'd0, cfg_error, cfg_ok}, 32'h2);
`else
            cmp_val("t6_err_ok", {30'd0, cfg_error, cfg_ok}, 32'h1);
`endif
        end

        // Zero-length frame.
        run_frame(4, 0, 0, 1, -1);
        cmp_val("len0_ok", 32'(cfg_ok), 32'd1);

        // Async reset in the middle of DATA.
        for (int k = 0; k < 10; k++) dbuf[k] = 1;
        run_frame(0, 10, 0, 0, 5);
        #1 rst_n = 0;
        exp_reset();
        #1;
        cmp_val("rst_mid_brb", 32'(|brbselect), 32'd0);
        cmp_val("rst_mid_lb", 32'(|lbselect), 32'd0);
        cmp_val("rst_mid_ready", 32'(cfg_ready), 32'd1);
        cmp_val("rst_mid_flags", {28'd0, cfg_busy, cfg_done, cfg_ok, cfg_error}, 32'd0);
        @(negedge clk); #2 rst_n = 1;

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            t = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6));
            w = width_of(t);
            r = $urandom_range(0, 9);
            if (r == 0) len = w + 1;
            else if (r == 1 && w <= 250) len = w;
            else if (r == 2) len = 0;
            else len = $urandom_range(1, (w < 40) ? w : 40);
            if (len <= 256)
                for (int k = 0; k < len; k++) dbuf[k] = 1'($urandom);
`ifdef CFG_PARITY_EN
            bad = ($urandom_range(0, 4) == 0);
`else
            bad = 0;
`endif
            run_frame(t, len, bad, 3, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
